data_mem_ctrl: RTL

Parametrised byte-addressable data memory with a valid/ready request/response handshake, configurable access latency and RISC-V sub-word load/store support (LB/LH/LW/LBU/LHU/SB/SH/SW). It replaces the single-cycle word data memory behind the CPU load/store path. It allows the pipeline to stall on memory and flags misaligned or out-of-range accesses. The byte array is named memory, so benches can preload it hierarchically.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_lane_align.sv | 31 +++
 rtl/data_mem_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants and types for the byte-addressable data memory controller:
// access-size encodings, controller FSM states and latency bounds.
package mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned READ_LATENCY_MIN = 1;
  localparam int unsigned READ_LATENCY_MAX = 4;
  localparam int unsigned LAT_CNT_W        = $clog2(READ_LATENCY_MAX);

  // Number of bytes touched by an access; 0 marks the reserved encoding.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  size_bytes = 3'd1;
      SIZE_H:  size_bytes = 3'd2;
      SIZE_W:  size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Load-path lane selection: shifts the addressed bytes of a little-endian word
// down to bit 0 and sign- or zero-extends them to the full data width.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      offset_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = word_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = '0;
    case (size_i)
      SIZE_B:  data_o = unsigned_i ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                   : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      SIZE_H:  data_o = unsigned_i ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                   : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      SIZE_W:  data_o = shifted;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory with valid/ready request/response handshake,
// configurable access latency and RISC-V sub-word load/store support.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES  = 256,
  parameter int READ_LATENCY = 1,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [31:0]     req_addr,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [LAT_CNT_W-1:0] CNT_LOAD = LAT_CNT_W'(READ_LATENCY - 1);

  logic [7:0] memory [DEPTH_BYTES];

  state_e                 state_q;
  logic [LAT_CNT_W-1:0]   cnt_q;
  logic                   we_q;
  logic [31:0]            addr_q;
  logic [1:0]             size_q;
  logic                   unsigned_q;
  logic [XLEN-1:0]        wdata_q;
  logic                   req_ready_q;
  logic                   rsp_valid_q;
  logic                   rsp_err_q;
  logic [XLEN-1:0]        rsp_rdata_q;

  logic                   commit;
  logic                   err_d;
  logic [32:0]            last_byte;
  logic [AW-1:0]          base_idx;
  logic [XLEN-1:0]        load_word;
  logic [XLEN-1:0]        load_data;
  logic [XLEN-1:0]        rdata_d;
  logic [3:0]             be_d;
  logic [XLEN-1:0]        wdata_lane;

  // 33-bit sum so a request near the top of the address space cannot wrap.
  assign last_byte = {1'b0, addr_q} + 33'(size_bytes(size_q)) - 33'd1;

  always_comb begin
    err_d = 1'b0;
    case (size_q)
      SIZE_B:  err_d = 1'b0;
      SIZE_H:  err_d = addr_q[0];
      SIZE_W:  err_d = |addr_q[1:0];
      default: err_d = 1'b1;
    endcase
    if (last_byte >= 33'(DEPTH_BYTES)) begin
      err_d = 1'b1;
    end
  end

  assign base_idx = addr_q[AW-1:0] & ~AW'(3);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign load_word[8*gi +: 8] = memory[base_idx | AW'(gi)];
    end
  endgenerate

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .word_i    (load_word),
    .offset_i  (addr_q[1:0]),
    .size_i    (size_q),
    .unsigned_i(unsigned_q),
    .data_o    (load_data)
  );

  assign rdata_d = (err_d || we_q) ? '0 : load_data;

  always_comb begin
    be_d = 4'b0000;
    case (size_q)
      SIZE_B:  be_d = 4'b0001 << addr_q[1:0];
      SIZE_H:  be_d = 4'b0011 << addr_q[1:0];
      SIZE_W:  be_d = 4'b1111;
      default: be_d = 4'b0000;
    endcase
  end

  assign wdata_lane = wdata_q << {addr_q[1:0], 3'b000};
  assign commit     = (state_q == ST_BUSY) && (cnt_q == '0);

  // Memory has no reset; an asynchronous reset forces IDLE, so no commit fires.
  always_ff @(posedge clk) begin
    if (commit && we_q && !err_d) begin
      for (int i = 0; i < 4; i++) begin
        if (be_d[i]) begin
          memory[base_idx | AW'(i)] <= wdata_lane[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      size_q      <= SIZE_B;
      unsigned_q  <= 1'b0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            size_q      <= req_size;
            unsigned_q  <= req_unsigned;
            wdata_q     <= req_wdata;
            cnt_q       <= CNT_LOAD;
            req_ready_q <= 1'b0;
            state_q     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_q == '0) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= err_d;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - LAT_CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
